axi4_s_wr_if: RTL and testbench

//  AXI4 slave write-channel front end of the DDR AXI4 arbiter; write-direction counterpart of the read-side slave IF.

---
 rtl/axi4_arb_pkg.sv | 21 ++
 rtl/axi4_s_wr_if_if.sv | 63 ++++++
 rtl/axi4_wr_data_fifo.sv | 71 +++++++
 rtl/axi4_s_wr_if.sv | 171 +++++++++++++++++
 tb/tb_axi4_s_wr_if.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/axi4_arb_pkg.sv
// Shared definitions for the DDR AXI4 arbiter slave interfaces.
// Holds the B-channel response codes, burst/beat counter widths and the
// write-side FSM state encoding.
package axi4_arb_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // AWLEN width and beat counter width (one extra bit so 256 beats fit).
  localparam int unsigned BURST_LEN_W = 8;
  localparam int unsigned BEAT_CNT_W  = BURST_LEN_W + 1;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_COLLECT = 3'd1,
    WR_REQ     = 3'd2,
    WR_XFER    = 3'd3,
    WR_RESP    = 3'd4
  } wr_state_e;

endpackage

// File: rtl/axi4_s_wr_if_if.sv
// Bus bundle for the AXI4 slave write front end.
// Carries the AXI AW/W/B channels and the arbiter-side write request,
// data streaming and completion signals.
//   slave  : view of the write front end (axi4_s_wr_if)
//   master : view of the AXI master / arbiter driving it
interface axi4_s_wr_if_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);

  // AXI write address channel
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [ID_W-1:0]   awid;
  logic              awvalid;
  logic              awready;
  // AXI write data channel
  logic [DATA_W-1:0] wdata;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  // AXI write response channel
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  // Arbiter side
  logic              w_req;
  logic              w_ack;
  logic [ADDR_W-1:0] w_start_addr;
  logic [7:0]        w_burst_size;
  logic [DATA_W-1:0] w_data;
  logic              w_data_rd;
  logic              w_done;

  modport slave (
    input  awaddr, awlen, awid, awvalid,
    output awready,
    input  wdata, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output w_req,
    input  w_ack,
    output w_start_addr, w_burst_size, w_data,
    input  w_data_rd, w_done
  );

  modport master (
    output awaddr, awlen, awid, awvalid,
    input  awready,
    output wdata, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  w_req,
    output w_ack,
    input  w_start_addr, w_burst_size, w_data,
    output w_data_rd, w_done
  );

endinterface

// File: rtl/axi4_wr_data_fifo.sv
// Synchronous first-word-fall-through FIFO buffering one write burst.
// Ports:
//   CLOCK_I, RESET_n_I : clock, async active-low reset
//   push, din          : write a word (ignored when full)
//   pop                : drop the head word (ignored when empty)
//   flush              : discard all contents (pointers reset), wins over push/pop
//   full, almost_full  : DEPTH / DEPTH-1 entries held
//   empty              : no entries
//   dout               : head word, 0 when empty
module axi4_wr_data_fifo #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 64
) (
  input  logic             CLOCK_I,
  input  logic             RESET_n_I,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (count == CNT_W'(DEPTH - 1));
  assign empty       = (count == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign dout        = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since validity is tracked by count.
  always_ff @(posedge CLOCK_I) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge CLOCK_I or negedge RESET_n_I) begin
    if (!RESET_n_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi4_s_wr_if.sv
// AXI4 slave write-channel front end of the DDR AXI4 arbiter.
// Accepts one AW burst, buffers its W beats, requests the arbiter, streams
// the buffered beats on demand and returns the B response on completion.
// Malformed bursts (WLAST early or missing) get SLVERR without an arbiter request.
// Ports:
//   CLOCK_I, RESET_n_I : clock, async active-low reset (aborts any burst)
//   bus                : AXI AW/W/B channels and arbiter request/data/done
module axi4_s_wr_if
  import axi4_arb_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH     = 256
) (
  input  logic           CLOCK_I,
  input  logic           RESET_n_I,
  axi4_s_wr_if_if.slave  bus
);

  if (FIFO_DEPTH < 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("axi4_s_wr_if: FIFO_DEPTH must be a power of two and at least 256");
  end

  wr_state_e                 state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BURST_LEN_W-1:0]    len_q, len_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [BEAT_CNT_W-1:0]     cnt_q, cnt_d;
  logic                      err_q, err_d;

  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic                      w_req_q, w_req_d;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_flush;
  logic                      fifo_full;
  logic                      fifo_almost_full;
  logic                      fifo_empty;

  axi4_wr_data_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXI_DATA_WIDTH)
  ) u_fifo (
    .CLOCK_I     (CLOCK_I),
    .RESET_n_I   (RESET_n_I),
    .push        (fifo_push),
    .din         (bus.wdata),
    .pop         (fifo_pop),
    .flush       (fifo_flush),
    .full        (fifo_full),
    .almost_full (fifo_almost_full),
    .empty       (fifo_empty),
    .dout        (bus.w_data)
  );

  // State, burst latches and registered handshake outputs.
  always_ff @(posedge CLOCK_I or negedge RESET_n_I) begin
    if (!RESET_n_I) begin
      state_q   <= WR_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= BRESP_OKAY;
      bid_q     <= '0;
      w_req_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      w_req_q   <= w_req_d;
    end
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (bus.awvalid && awready_q) begin
          addr_d  = bus.awaddr;
          len_d   = bus.awlen;
          id_d    = bus.awid;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = WR_COLLECT;
        end
      end
      WR_COLLECT: begin
        if (bus.wvalid && wready_q) begin
          if (err_q) begin
            // Overlong burst: swallow beats until WLAST.
            if (bus.wlast) state_d = WR_RESP;
          end else begin
            fifo_push = 1'b1;
            cnt_d     = cnt_q + BEAT_CNT_W'(1);
            if (bus.wlast) begin
              if (cnt_q == {1'b0, len_q}) begin
                state_d = WR_REQ;
              end else begin
                err_d   = 1'b1;
                state_d = WR_RESP;
              end
            end else if (cnt_q == {1'b0, len_q}) begin
              err_d = 1'b1;
            end
          end
        end
      end
      WR_REQ: begin
        if (bus.w_ack) state_d = WR_XFER;
      end
      WR_XFER: begin
        fifo_pop = bus.w_data_rd && !fifo_empty;
        if (bus.w_done) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid_q && bus.bready) state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase

    // Unpopped or errored data never survives into the response phase.
    fifo_flush = (state_d == WR_RESP) && (state_q != WR_RESP);

    awready_d = (state_d == WR_IDLE);
    // Discarding beats never writes the FIFO, so fullness is irrelevant then.
    wready_d  = (state_d == WR_COLLECT) &&
                (err_d || !(fifo_full || (fifo_push && fifo_almost_full)));
    w_req_d   = (state_d == WR_REQ);
    bvalid_d  = (state_d == WR_RESP);
    bresp_d   = ((state_d == WR_RESP) && err_d) ? BRESP_SLVERR : BRESP_OKAY;
    bid_d     = (state_d == WR_RESP) ? id_d : '0;
  end

  assign bus.awready      = awready_q;
  assign bus.wready       = wready_q;
  assign bus.bvalid       = bvalid_q;
  assign bus.bresp        = bresp_q;
  assign bus.bid          = bid_q;
  assign bus.w_req        = w_req_q;
  assign bus.w_start_addr = addr_q;
  assign bus.w_burst_size = len_q;

endmodule

// File: tb/tb_axi4_s_wr_if.sv
// Self-checking bench for axi4_s_wr_if: directed vector table, hand-written
// reset/ignore sequences and randomized bursts against a burst-level model.
module tb_axi4_s_wr_if;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_pass   = 0;

  axi4_s_wr_if_if bus ();

  axi4_s_wr_if #(
    .AXI_DATA_WIDTH (64),
    .AXI_ADDR_WIDTH (32),
    .AXI_ID_WIDTH   (4),
    .FIFO_DEPTH     (256)
  ) dut (
    .CLOCK_I   (clk),
    .RESET_n_I (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          nbeats;
    int          ack_dly;
    int          npops;
    int          bready_dly;
    logic [31:0] addr;
    logic [63:0] base;
    logic [1:0]  exp_resp;
    bit          exp_req;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.awaddr = '0; bus.awlen = '0; bus.awid = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.w_ack = 1'b0; bus.w_data_rd = 1'b0; bus.w_done = 1'b0;
  endtask

  // Full burst: AW, W beats, optional arbiter transfer, B response.
  task automatic run_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int nbeats, input int ack_dly, input int npops,
                           input int bready_dly, input logic [1:0] exp_resp,
                           input bit exp_req, input logic [63:0] base, input bit gaps,
                           input string tag);
    logic [63:0] data[$];
    logic [63:0] exp_d;
    int n;
    bit tout;
    bit stable;
    for (int i = 0; i < nbeats; i++)
      data.push_back(base != 0 ? base + 64'(i) : {$urandom, $urandom});

    @(negedge clk);
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awid = id; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    check({tag, " aw_timeout"}, 64'(n >= 50), 64'(0));
    @(negedge clk);
    bus.awvalid = 1'b0;

    tout = 1'b0;
    for (int i = 0; i < nbeats && !tout; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0; @(negedge clk);
      end
      bus.wvalid = 1'b1; bus.wdata = data[i]; bus.wlast = (i == nbeats - 1);
      n = 0;
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) tout = 1'b1;
      else @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check({tag, " w_timeout"}, 64'(tout), 64'(0));
    check({tag, " w_req_after_last"}, 64'(bus.w_req), 64'(exp_req));

    if (exp_req) begin
      check({tag, " start_addr"}, 64'(bus.w_start_addr), 64'(addr));
      check({tag, " burst_size"}, 64'(bus.w_burst_size), 64'(len));
      stable = 1'b1;
      for (int c = 0; c < ack_dly; c++) begin
        @(negedge clk);
        if (bus.w_req !== 1'b1 || bus.wready !== 1'b0 || bus.awready !== 1'b0) stable = 1'b0;
      end
      check({tag, " req_hold"}, 64'(stable), 64'(1));
      bus.w_ack = 1'b1; @(negedge clk); bus.w_ack = 1'b0;
      check({tag, " req_drop"}, 64'(bus.w_req), 64'(0));
      for (int k = 0; k < npops; k++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          bus.w_data_rd = 1'b0; @(negedge clk);
        end
        exp_d = (k < data.size()) ? data[k] : 64'(0);
        check($sformatf("%s pop%0d", tag, k), bus.w_data, exp_d);
        bus.w_data_rd = 1'b1; @(negedge clk);
      end
      bus.w_data_rd = 1'b0;
      bus.w_done = 1'b1; @(negedge clk); bus.w_done = 1'b0;
    end

    check({tag, " bvalid"}, 64'(bus.bvalid), 64'(1));
    check({tag, " bresp"}, 64'(bus.bresp), 64'(exp_resp));
    check({tag, " bid"}, 64'(bus.bid), 64'(id));
    check({tag, " flushed"}, bus.w_data, 64'(0));
    stable = 1'b1;
    for (int c = 0; c < bready_dly; c++) begin
      @(negedge clk);
      if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp || bus.bid !== id ||
          bus.awready !== 1'b0 || bus.w_req !== 1'b0) stable = 1'b0;
    end
    check({tag, " b_hold"}, 64'(stable), 64'(1));
    bus.bready = 1'b1; @(negedge clk); bus.bready = 1'b0;
    check({tag, " b_done"}, 64'({bus.bvalid, bus.awready}), 64'(2'b01));
  endtask

  initial begin
    int len, nb, np;
    bit ok;

    // len, nbeats, ack_dly, npops, bready_dly, addr, base, exp_resp, exp_req
    vecs[0] = '{3,   4,   0,  4,   0, 32'h0000_1000, 64'hA0,        2'b00, 1'b1};
    vecs[1] = '{255, 256, 10, 256, 0, 32'h0002_0000, 64'h1_0000,    2'b00, 1'b1};
    vecs[2] = '{3,   2,   0,  0,   0, 32'h0000_3000, 64'hE0,        2'b10, 1'b0};
    vecs[3] = '{3,   4,   1,  4,   1, 32'h0000_4000, 64'hC0,        2'b00, 1'b1};
    vecs[4] = '{1,   4,   0,  0,   0, 32'h0000_5000, 64'hD0,        2'b10, 1'b0};
    vecs[5] = '{3,   4,   0,  2,   5, 32'h0000_6000, 64'hB0,        2'b00, 1'b1};
    vecs[6] = '{0,   1,   3,  2,   2, 32'h0000_7000, 64'hF0,        2'b00, 1'b1};
    vecs[7] = '{0,   2,   0,  0,   1, 32'h0000_8000, 64'h90,        2'b10, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hs", 64'({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.bid, bus.w_req}), 64'(0));
    check("reset_addr", 64'({bus.w_start_addr, bus.w_burst_size}), 64'(0));
    check("reset_data", bus.w_data, 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_awready", 64'(bus.awready), 64'(1));

    // Arbiter/response strobes while idle must be ignored.
    bus.w_ack = 1'b1; bus.w_done = 1'b1; bus.w_data_rd = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("idle_ignore", 64'({bus.awready, bus.bvalid, bus.w_req, bus.wready}), 64'(4'b1000));

    for (int v = 0; v < 8; v++)
      run_burst(vecs[v].addr, vecs[v].len, 4'(v + 3), vecs[v].nbeats, vecs[v].ack_dly,
                vecs[v].npops, vecs[v].bready_dly, vecs[v].exp_resp, vecs[v].exp_req,
                vecs[v].base, 1'b0, $sformatf("vec%0d", v));

    // Reset asserted in the middle of XFER.
    @(negedge clk);
    bus.awaddr = 32'h9000; bus.awlen = 8'd1; bus.awid = 4'h5; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 64'h11; bus.wlast = 1'b0;
    @(negedge clk);
    bus.wdata = 64'h22; bus.wlast = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("rst_seq_req", 64'(bus.w_req), 64'(1));
    bus.w_ack = 1'b1; @(negedge clk); bus.w_ack = 1'b0;
    bus.w_data_rd = 1'b1; @(negedge clk); bus.w_data_rd = 1'b0;
    check("rst_seq_head", bus.w_data, 64'h22);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_hs", 64'({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.bid, bus.w_req}), 64'(0));
    check("rst_mid_addr", 64'({bus.w_start_addr, bus.w_burst_size}), 64'(0));
    check("rst_mid_data", bus.w_data, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_no_b", 64'({bus.bvalid, bus.awready}), 64'(2'b01));
    run_burst(32'hA000, 2, 4'h9, 3, 2, 3, 1, 2'b00, 1'b1, 64'h300, 1'b0, "post_rst");

    // Randomized bursts: a burst is good exactly when beat count equals len+1.
    for (int r = 0; r < 25; r++) begin
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 6) nb = len + 1;
      else nb = int'($urandom_range(1, len + 4));
      ok = (nb == len + 1);
      np = ok ? int'($urandom_range(0, nb + 2)) : 0;
      run_burst($urandom, len, 4'($urandom_range(0, 15)), nb, int'($urandom_range(0, 4)), np,
                int'($urandom_range(0, 3)), ok ? 2'b00 : 2'b10, ok, 64'(0), 1'b1,
                $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
